apb_matmul_ctrl: RTL and testbench
==================================

// Module: apb_matmul_ctrl
// PURPOSE
//  APB3 register front-end and result-writeback controller for the systolic matmul core, parametrised in
//  data width, matrix dimension and scratchpad count. Holds operands A/B, control and flags; starts the array,
//  then writes the results element-by-element into a selectable scratchpad target. Serves APB reads while busy.
// PARAMETERS
//  DW           8    element width (bits)
//  BW           32   APB data width; MAX_DIM = BW/DW elements per row
//  ADDR_W       16   APB address width
//  SP_NTARGETS  4    scratchpad matrices (1..4)
//  MAX_DIM      BW/DW  matrix dimension; E = MAX_DIM*MAX_DIM elements
// PORTS
//  clk_i          in   1         clock, rising edge
//  reset_i        in   1         asynchronous, active-high reset
//  psel_i         in   1         APB select
//  penable_i      in   1         APB access phase
//  pwrite_i       in   1         1=write, 0=read
//  pstrb_i        in   BW/8      byte-lane write strobes
//  paddr_i        in   ADDR_W    byte address
//  pwdata_i       in   BW        write data
//  prdata_o       out  BW        read data
//  pready_o       out  1         transfer complete
//  pslverr_o      out  1         transfer error (valid with pready_o)
//  done_i         in   1         array result valid (level)
//  of_i           in   E         per-element overflow flags
//  result_i       in   BW*E      flattened result matrix, element 0 in LSBs
//  operand_a_o    out  BW*MAX_DIM  matrix A rows
//  operand_b_o    out  BW*MAX_DIM  matrix B rows
//  operand_c_o    out  BW*E      bias matrix (selected SP, or 0 if CTRL[1]=0)
//  control_reg_o  out  16        CTRL register
//  busy_o         out  1         engine running or writing back
//  done_o         out  1         one-cycle pulse at end of writeback
// BEHAVIOUR
//  Reset: all outputs, CTRL, FLAGS, operands, SP contents, counters = 0; both FSMs to IDLE.
//  Map (paddr[4:0]): 0x00 CTRL, 0x04 OPA, 0x08 OPB, 0x0C FLAGS, 0x10+4*t SP target t. Row/element index = paddr[ADDR_W-1:5].
//  CTRL: [0] start, [1] bias_en, [3:2] SP write target, [5:4] bias/C source SP, [15:6] reserved (read as written).
//  APB FSM {IDLE, RESP}: psel&penable in IDLE -> RESP; RESP drives pready_o=1 for exactly one cycle (one wait state),
//   prdata_o/pslverr_o registered and valid that cycle, zero otherwise. Back-to-back transfers supported.
//  Writes honour pstrb_i per byte; OPA/OPB row index >= MAX_DIM, SP/element index >= E, target >= SP_NTARGETS,
//   or unmapped offset -> pslverr=1, no state change, prdata=0. SP and FLAGS are read-only: write -> pslverr=1.
//  While busy_o=1: writes to CTRL/OPA/OPB -> pslverr=1 and are discarded; all reads succeed.
//  Engine FSM {IDLE, RUN, WB}: IDLE->RUN on CTRL write with pwdata[0]=1 (busy_o=1 next cycle).
//   RUN: operand_c_o = bias_en ? SP[CTRL[5:4]] : 0, held until IDLE. done_i=1 -> capture result_i,of_i into shadow, ->WB.
//   WB: counter 0..E-1, one element per cycle into SP[CTRL[3:2]][cnt]; latency done_i->done_o = E+1 cycles.
//   At cnt=E-1: FLAGS<=captured of_i, CTRL[0]<=0, busy_o<=0, done_o pulse, ->IDLE.
//  done_i in IDLE or WB: ignored. WB target == bias source: allowed (C already latched in RUN).
//  Same-cycle APB read of SP element being written in WB returns the pre-write value.
//  reset_i mid-RUN/WB: immediate abort, SP partially written contents cleared, no done_o.
// STRUCTURE
//  Package apb_matmul_pkg: address offset constants, CTRL bit indices, FSM state encodings, index-width functions.
//  Sub-module apb_sp_bank: SP_NTARGETS x E x BW array, one sync write port, one async APB read port, one full-matrix port.
//  Operand A/B stores, CTRL, FLAGS, both FSMs inline in this module.
// TESTING
//  1. reset_i pulse mid-traffic -> all outputs 0; read CTRL -> 0x0000, pready after 1 wait state, pslverr=0.
//  2. Write OPA row1=0x04030201 pstrb=0b0101 -> read row1 = 0x00030001; write OPA row MAX_DIM -> pslverr=1.
//  3. CTRL=0x0009 (start, target 2), done_i with result_i element k=k+1 -> E+1 cycles later done_o=1,
//     SP2[k]=k+1, CTRL reads 0x0008, busy_o=0.
//  4. During RUN write OPB -> pslverr=1, OPB unchanged; read FLAGS -> ok; of_i=0x8001 at done -> FLAGS=0x8001.
//  5. CTRL[1]=1, CTRL[5:4]=2 with SP2 preloaded, start -> operand_c_o = SP2 contents throughout RUN/WB.
//  6. reset_i asserted at WB cnt=3 -> busy_o=0, done_o never pulses, SP read -> 0.

Source files
------------

// File: rtl/apb_matmul_pkg.sv
// Shared definitions for the matmul APB controller.
// Contents: register offsets, CTRL bit positions, FSM state encodings, and an index-width helper.
package apb_matmul_pkg;

  // Register offsets within the 32-byte window selected by paddr[4:0]
  localparam logic [4:0] OffCtrl   = 5'h00;
  localparam logic [4:0] OffOpa    = 5'h04;
  localparam logic [4:0] OffOpb    = 5'h08;
  localparam logic [4:0] OffFlags  = 5'h0C;

  // CTRL bit positions
  localparam int unsigned CtrlStart  = 0;
  localparam int unsigned CtrlBiasEn = 1;
  localparam int unsigned CtrlTgtLo  = 2;
  localparam int unsigned CtrlSrcLo  = 4;

  typedef enum logic {ApbIdle, ApbResp} apb_state_e;
  typedef enum logic [1:0] {EngIdle, EngRun, EngWb} eng_state_e;

  // Bits needed to index n entries (at least one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_sp_bank.sv
// Scratchpad bank: SP_NTARGETS matrices of E elements, each BW bits wide.
// Ports: clk_i/reset_i (async, active-high clear of all contents); we_i/wr_tgt_i/wr_idx_i/wr_data_i
// sync write port; rd_tgt_i/rd_idx_i -> rd_data_o async read port; full_tgt_i -> full_o whole-matrix
// read (element 0 in LSBs). Out-of-range targets read as zero and ignore writes.
module apb_sp_bank
  import apb_matmul_pkg::*;
#(
  parameter int unsigned BW          = 32,
  parameter int unsigned E           = 16,
  parameter int unsigned SP_NTARGETS = 4,
  localparam int unsigned EW         = idx_w(E)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            we_i,
  input  logic [1:0]      wr_tgt_i,
  input  logic [EW-1:0]   wr_idx_i,
  input  logic [BW-1:0]   wr_data_i,
  input  logic [1:0]      rd_tgt_i,
  input  logic [EW-1:0]   rd_idx_i,
  output logic [BW-1:0]   rd_data_o,
  input  logic [1:0]      full_tgt_i,
  output logic [BW*E-1:0] full_o
);

  logic [SP_NTARGETS-1:0][E-1:0][BW-1:0] mem_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q <= '0;
    end else if (we_i && (32'(wr_tgt_i) < SP_NTARGETS)) begin
      mem_q[wr_tgt_i][wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = ((32'(rd_tgt_i) < SP_NTARGETS) && (32'(rd_idx_i) < E)) ?
                     mem_q[rd_tgt_i][rd_idx_i] : '0;
  assign full_o    = (32'(full_tgt_i) < SP_NTARGETS) ? mem_q[full_tgt_i] : '0;

endmodule

// File: rtl/apb_matmul_ctrl.sv
// APB3 front-end and result-writeback controller for the systolic matmul core.
// Ports: APB slave (psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i -> prdata_o, pready_o,
// pslverr_o) with one wait state; array handshake done_i/of_i/result_i; operand_a_o/operand_b_o
// row stores, operand_c_o bias matrix, control_reg_o (CTRL), busy_o, done_o (end-of-writeback pulse).
module apb_matmul_ctrl
  import apb_matmul_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned BW          = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SP_NTARGETS = 4,
  parameter int unsigned MAX_DIM     = BW / DW,
  localparam int unsigned E          = MAX_DIM * MAX_DIM
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [BW/8-1:0]       pstrb_i,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic [BW-1:0]         pwdata_i,
  output logic [BW-1:0]         prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic                  done_i,
  input  logic [E-1:0]          of_i,
  input  logic [BW*E-1:0]       result_i,
  output logic [BW*MAX_DIM-1:0] operand_a_o,
  output logic [BW*MAX_DIM-1:0] operand_b_o,
  output logic [BW*E-1:0]       operand_c_o,
  output logic [15:0]           control_reg_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned NB = BW / 8;
  localparam int unsigned RW = idx_w(MAX_DIM);
  localparam int unsigned EW = idx_w(E);
  localparam int unsigned IW = ADDR_W - 5;

  apb_state_e apb_q, apb_d;
  eng_state_e eng_q, eng_d;

  logic [15:0]                   ctrl_q, ctrl_d, ctrl_new;
  logic [MAX_DIM-1:0][BW-1:0]    opa_q, opb_q;
  logic [E-1:0]                  flags_q, of_q;
  logic [E-1:0][BW-1:0]          res_q, c_q;
  logic [EW-1:0]                 cnt_q;
  logic [BW-1:0]                 prdata_q, rdata, sp_rd;
  logic                          pslverr_q, done_q;
  logic [BW*E-1:0]               sp_full;

  logic [4:0]    off;
  logic [IW-1:0] idx;
  logic [RW-1:0] row;
  logic          access, busy, sp_sel, row_ok, elem_ok, err;
  logic          wr_ctrl, wr_opa, wr_opb, start, wb_last;

  function automatic logic [BW-1:0] merge_bytes(input logic [BW-1:0] old_v,
                                                input logic [BW-1:0] new_v,
                                                input logic [NB-1:0] strb);
    logic [BW-1:0] v;
    v = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
    end
    return v;
  endfunction

  assign off     = paddr_i[4:0];
  assign idx     = paddr_i[ADDR_W-1:5];
  assign row     = idx[RW-1:0];
  assign access  = (apb_q == ApbIdle) && psel_i && penable_i;
  assign busy    = (eng_q != EngIdle);
  assign sp_sel  = off[4] && (off[1:0] == 2'b00);
  assign row_ok  = 32'(idx) < MAX_DIM;
  assign elem_ok = 32'(idx) < E;
  assign wb_last = (eng_q == EngWb) && (cnt_q == EW'(E - 1));

  // Register decode; wr_* are only raised for error-free writes
  always_comb begin
    err     = 1'b0;
    rdata   = '0;
    wr_ctrl = 1'b0;
    wr_opa  = 1'b0;
    wr_opb  = 1'b0;
    if (sp_sel) begin
      if (pwrite_i || !elem_ok || (32'(off[3:2]) >= SP_NTARGETS)) err = 1'b1;
      else rdata = sp_rd;
    end else begin
      unique case (off)
        OffCtrl: begin
          if (!pwrite_i) rdata = BW'(ctrl_q);
          else if (busy) err = 1'b1;
          else wr_ctrl = 1'b1;
        end
        OffOpa: begin
          if (!row_ok) err = 1'b1;
          else if (!pwrite_i) rdata = opa_q[row];
          else if (busy) err = 1'b1;
          else wr_opa = 1'b1;
        end
        OffOpb: begin
          if (!row_ok) err = 1'b1;
          else if (!pwrite_i) rdata = opb_q[row];
          else if (busy) err = 1'b1;
          else wr_opb = 1'b1;
        end
        OffFlags: begin
          if (pwrite_i) err = 1'b1;
          else rdata = BW'(flags_q);
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_comb begin
    ctrl_new = ctrl_q;
    for (int b = 0; b < 2; b++) begin
      if (pstrb_i[b]) ctrl_new[8*b +: 8] = pwdata_i[8*b +: 8];
    end
  end

  assign start = access && wr_ctrl && ctrl_new[CtrlStart];

  always_comb begin
    ctrl_d = ctrl_q;
    if (access && wr_ctrl) ctrl_d = ctrl_new;
    if (wb_last) ctrl_d[CtrlStart] = 1'b0;
  end

  always_comb begin
    apb_d = apb_q;
    unique case (apb_q)
      ApbIdle: if (access) apb_d = ApbResp;
      ApbResp: apb_d = ApbIdle;
    endcase
  end

  always_comb begin
    eng_d = eng_q;
    unique case (eng_q)
      EngIdle: if (start) eng_d = EngRun;
      EngRun:  if (done_i) eng_d = EngWb;
      EngWb:   if (wb_last) eng_d = EngIdle;
      default: eng_d = EngIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      apb_q     <= ApbIdle;
      eng_q     <= EngIdle;
      ctrl_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      flags_q   <= '0;
      of_q      <= '0;
      res_q     <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      apb_q     <= apb_d;
      eng_q     <= eng_d;
      ctrl_q    <= ctrl_d;
      prdata_q  <= (access && !err) ? rdata : '0;
      pslverr_q <= access && err;
      if (access && wr_opa) opa_q[row] <= merge_bytes(opa_q[row], pwdata_i, pstrb_i);
      if (access && wr_opb) opb_q[row] <= merge_bytes(opb_q[row], pwdata_i, pstrb_i);
      // Bias is latched at start so writeback may safely overwrite the source matrix
      if (start) c_q <= ctrl_d[CtrlBiasEn] ? sp_full : '0;
      else if (wb_last) c_q <= '0;
      if ((eng_q == EngRun) && done_i) begin
        res_q <= result_i;
        of_q  <= of_i;
        cnt_q <= '0;
      end else if (eng_q == EngWb) begin
        cnt_q <= wb_last ? '0 : cnt_q + EW'(1);
      end
      if (wb_last) flags_q <= of_q;
      done_q <= wb_last;
    end
  end

  apb_sp_bank #(
    .BW          (BW),
    .E           (E),
    .SP_NTARGETS (SP_NTARGETS)
  ) u_sp_bank (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .we_i       (eng_q == EngWb),
    .wr_tgt_i   (ctrl_q[CtrlTgtLo +: 2]),
    .wr_idx_i   (cnt_q),
    .wr_data_i  (res_q[cnt_q]),
    .rd_tgt_i   (off[3:2]),
    .rd_idx_i   (idx[EW-1:0]),
    .rd_data_o  (sp_rd),
    .full_tgt_i (ctrl_d[CtrlSrcLo +: 2]),
    .full_o     (sp_full)
  );

  assign prdata_o      = prdata_q;
  assign pready_o      = (apb_q == ApbResp);
  assign pslverr_o     = pslverr_q;
  assign operand_a_o   = opa_q;
  assign operand_b_o   = opb_q;
  assign operand_c_o   = c_q;
  assign control_reg_o = ctrl_q;
  assign busy_o        = busy;
  assign done_o        = done_q;

endmodule

// File: tb/tb_apb_matmul_ctrl.sv
module tb_apb_matmul_ctrl;

  localparam int E = 16;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         psel, penable, pwrite;
  logic [3:0]   pstrb;
  logic [15:0]  paddr;
  logic [31:0]  pwdata, prdata_o;
  logic         pready_o, pslverr_o;
  logic         done_i;
  logic [15:0]  of_i;
  logic [511:0] result_i;
  logic [127:0] operand_a_o, operand_b_o;
  logic [511:0] operand_c_o;
  logic [15:0]  control_reg_o;
  logic         busy_o, done_o;

  typedef struct packed {logic [31:0] data; logic err;} rsp_t;
  rsp_t sb_q[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_matmul_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pstrb_i       (pstrb),
    .paddr_i       (paddr),
    .pwdata_i      (pwdata),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .done_i        (done_i),
    .of_i          (of_i),
    .result_i      (result_i),
    .operand_a_o   (operand_a_o),
    .operand_b_o   (operand_b_o),
    .operand_c_o   (operand_c_o),
    .control_reg_o (control_reg_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response was sampled
  task automatic apb(input string tag, input bit wr, input logic [15:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_data, input logic exp_err);
    rsp_t r;
    int waits;
    logic [31:0] got_d;
    logic got_e;
    sb_q.push_back('{data: exp_data, err: exp_err});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!pready_o && waits < 8);
    got_d = prdata_o;
    got_e = pslverr_o;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    r = sb_q.pop_front();
    chk({tag, ".wait"}, 512'(waits), 512'(1));
    chk({tag, ".err"}, 512'(got_e), 512'(r.err));
    chk({tag, ".data"}, 512'(got_d), 512'(r.data));
  endtask

  function automatic logic [15:0] sp_addr(input int t, input int k);
    return 16'((k << 5) | (16 + 4 * t));
  endfunction

  logic [511:0] res3, res5;
  int j;
  bit seen;

  initial begin
    reset_i = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    paddr = '0; pwdata = '0; done_i = 1'b0; of_i = '0; result_i = '0;
    for (int k = 0; k < E; k++) begin
      res3[32*k +: 32] = 32'(k + 1);
      res5[32*k +: 32] = 32'(3 * k + 100);
    end
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // 1: reset in the middle of a transfer
    apb("t1.wr_opa0", 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    psel = 1'b1; pwrite = 1'b0; paddr = 16'h0004;
    @(negedge clk);
    penable = 1'b1;
    #2 reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("t1.pready", 512'(pready_o), 512'(0));
    chk("t1.prdata", 512'(prdata_o), 512'(0));
    chk("t1.pslverr", 512'(pslverr_o), 512'(0));
    chk("t1.opa", 512'(operand_a_o), 512'(0));
    chk("t1.opc", operand_c_o, 512'(0));
    chk("t1.ctrl_o", 512'(control_reg_o), 512'(0));
    chk("t1.busy_done", 512'({busy_o, done_o}), 512'(0));
    apb("t1.rd_ctrl", 1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, 1'b0);

    // 2: byte strobes and out-of-range / read-only errors
    apb("t2.wr_opa1", 1'b1, 16'h0024, 32'h04030201, 4'b0101, 32'h0, 1'b0);
    apb("t2.rd_opa1", 1'b0, 16'h0024, 32'h0, 4'h0, 32'h00030001, 1'b0);
    chk("t2.opa_o", 512'(operand_a_o[63:32]), 512'(32'h00030001));
    apb("t2.wr_opa4", 1'b1, 16'h0084, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    apb("t2.rd_opa4", 1'b0, 16'h0084, 32'h0, 4'h0, 32'h0, 1'b1);
    apb("t2.wr_sp", 1'b1, sp_addr(0, 0), 32'h1, 4'hF, 32'h0, 1'b1);
    apb("t2.wr_flags", 1'b1, 16'h000C, 32'h1, 4'hF, 32'h0, 1'b1);
    apb("t2.rd_unmap", 1'b0, 16'h0002, 32'h0, 4'h0, 32'h0, 1'b1);
    apb("t2.rd_sp_e", 1'b0, sp_addr(1, E), 32'h0, 4'h0, 32'h0, 1'b1);
    apb("t2.wr_opb0", 1'b1, 16'h0008, 32'h11223344, 4'hF, 32'h0, 1'b0);

    // 3/4: run into SP2, blocked writes while busy, overflow flags
    apb("t3.start", 1'b1, 16'h0000, 32'h0009, 4'h3, 32'h0, 1'b0);
    chk("t3.busy", 512'(busy_o), 512'(1));
    chk("t3.opc_nobias", operand_c_o, 512'(0));
    apb("t4.wr_opb_busy", 1'b1, 16'h0008, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    apb("t4.wr_ctrl_busy", 1'b1, 16'h0000, 32'h0000, 4'h3, 32'h0, 1'b1);
    apb("t4.rd_flags", 1'b0, 16'h000C, 32'h0, 4'h0, 32'h0, 1'b0);
    apb("t4.rd_ctrl", 1'b0, 16'h0000, 32'h0, 4'h0, 32'h9, 1'b0);
    result_i = res3; of_i = 16'h8001; done_i = 1'b1;
    j = 0;
    do begin
      @(negedge clk);
      done_i = 1'b0;
      j++;
    end while (!done_o && j < 40);
    chk("t3.latency", 512'(j), 512'(E + 1));
    chk("t3.busy_end", 512'(busy_o), 512'(0));
    @(negedge clk);
    chk("t3.done_pulse", 512'(done_o), 512'(0));
    apb("t3.rd_ctrl", 1'b0, 16'h0000, 32'h0, 4'h0, 32'h8, 1'b0);
    apb("t4.rd_flags2", 1'b0, 16'h000C, 32'h0, 4'h0, 32'h8001, 1'b0);
    apb("t4.rd_opb0", 1'b0, 16'h0008, 32'h0, 4'h0, 32'h11223344, 1'b0);
    for (int k = 0; k < E; k += 5) begin
      apb($sformatf("t3.sp2_%0d", k), 1'b0, sp_addr(2, k), 32'h0, 4'h0, 32'(k + 1), 1'b0);
    end
    apb("t3.sp2_15", 1'b0, sp_addr(2, 15), 32'h0, 4'h0, 32'd16, 1'b0);

    // 5: bias from SP2 while writing back into SP2
    apb("t5.start", 1'b1, 16'h0000, 32'h002B, 4'h3, 32'h0, 1'b0);
    chk("t5.opc_run", operand_c_o, res3);
    result_i = res5; of_i = 16'h0; done_i = 1'b1;
    j = 0;
    do begin
      @(negedge clk);
      done_i = 1'b0;
      j++;
      if (j == 1 || j == 8 || j == E) chk($sformatf("t5.opc_wb%0d", j), operand_c_o, res3);
    end while (!done_o && j < 40);
    chk("t5.latency", 512'(j), 512'(E + 1));
    apb("t5.sp2_3", 1'b0, sp_addr(2, 3), 32'h0, 4'h0, 32'd109, 1'b0);
    apb("t5.flags", 1'b0, 16'h000C, 32'h0, 4'h0, 32'h0, 1'b0);

    // 6: reset during writeback
    apb("t6.start", 1'b1, 16'h0000, 32'h0009, 4'h3, 32'h0, 1'b0);
    result_i = res3; done_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      done_i = 1'b0;
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("t6.busy", 512'(busy_o), 512'(0));
    chk("t6.ctrl_o", 512'(control_reg_o), 512'(0));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk("t6.no_done", 512'(seen), 512'(0));
    apb("t6.sp2_0", 1'b0, sp_addr(2, 0), 32'h0, 4'h0, 32'h0, 1'b0);
    apb("t6.sp2_2", 1'b0, sp_addr(2, 2), 32'h0, 4'h0, 32'h0, 1'b0);
    apb("t6.sp2_9", 1'b0, sp_addr(2, 9), 32'h0, 4'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
